// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-client single-port RAM controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;   // holds STROBE_LEN-1 for STROBE_LEN up to 15

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WSTROBE,
        WHOLD,
        RSETUP,
        RSTROBE,
        RTURN
    } state_t;

    typedef logic client_id_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Client-side request/response bundle for both requesters of the RAM controller.
// Latency: n/a (wires only).
// Backpressure: requests held by the client until rqN_ready; responses cannot be stalled.
interface ram_arbiter_if #(
    parameter int ADDR_W = ram_arbiter_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_arbiter_pkg::DATA_W_DEF
);

    logic              rq0_valid;
    logic              rq0_write;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic              rq0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              rq1_valid;
    logic              rq1_write;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata;
    logic              rq1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    modport master (
        output rq0_valid, rq0_write, rq0_addr, rq0_wdata,
        input  rq0_ready, rsp0_valid, rsp0_rdata,
        output rq1_valid, rq1_write, rq1_addr, rq1_wdata,
        input  rq1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  rq0_valid, rq0_write, rq0_addr, rq0_wdata,
        output rq0_ready, rsp0_valid, rsp0_rdata,
        input  rq1_valid, rq1_write, rq1_addr, rq1_wdata,
        output rq1_ready, rsp1_valid, rsp1_rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin grant; pointer moves past the served client on accept.
// Latency: grant is combinational from req/enable; pointer updates at the accept edge.
// Backpressure: no grant while enable is low; an ungranted request simply waits.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output client_id_t grant_id
);

    client_id_t ptr;

    // Favoured client wins; otherwise the other one if it is requesting.
    always_comb begin
        grant    = '0;
        grant_id = ptr;
        if (enable) begin
            if (req[ptr]) begin
                grant[ptr] = 1'b1;
                grant_id   = ptr;
            end else if (req[~ptr]) begin
                grant[~ptr] = 1'b1;
                grant_id    = ~ptr;
            end
        end
    end

    // After serving a client, the other one becomes favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~grant_id;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin controller sequencing we/re strobes of a single-port RAM for two clients.
// Latency: read response 2+STROBE_LEN cycles after accept; write busy 2+STROBE_LEN cycles.
// Backpressure: rqN_ready only in IDLE for the granted client; responses are one-cycle pulses.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STROBE_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      cl,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_LEN - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rd_data;
    client_id_t        cap_id;
    logic [1:0]        grant;
    client_id_t        grant_id;
    logic              accept;
    logic              sel_write;
    logic              bus_drv;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .enable   (state == IDLE),
        .req      ({cl.rq1_valid, cl.rq0_valid}),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grants are only issued to a valid requester, so any grant is a handshake.
    assign accept       = |grant;
    assign sel_write    = grant_id ? cl.rq1_write : cl.rq0_write;
    assign cl.rq0_ready = grant[0];
    assign cl.rq1_ready = grant[1];

    // The captured address feeds the RAM directly so it holds from SETUP to the end.
    assign ram_addr      = cap_addr;
    assign ram_data      = bus_drv ? cap_wdata : {DATA_W{1'bz}};
    assign cl.rsp0_rdata = rd_data;
    assign cl.rsp1_rdata = rd_data;

    // State and strobe counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the granted request; sample read data on the edge ending the last strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_id    <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (accept) begin
                cap_id    <= grant_id;
                cap_addr  <= grant_id ? cl.rq1_addr  : cl.rq0_addr;
                cap_wdata <= grant_id ? cl.rq1_wdata : cl.rq0_wdata;
            end
            if (state == RSTROBE && cnt == '0) begin
                rd_data <= ram_data;
            end
        end
    end

    // Next-state, counter and strobe decode; bus drive and ram_re never share a state,
    // and RTURN plus IDLE separate a read strobe from the next write drive.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        bus_drv       = 1'b0;
        cl.rsp0_valid = 1'b0;
        cl.rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = sel_write ? WSETUP : RSETUP;
            end
            WSETUP: begin
                bus_drv   = 1'b1;
                cnt_nxt   = STROBE_LAST;
                state_nxt = WSTROBE;
            end
            WSTROBE: begin
                bus_drv = 1'b1;
                ram_we  = 1'b1;
                if (cnt == '0) state_nxt = WHOLD;
                else           cnt_nxt   = cnt - 1'b1;
            end
            WHOLD: begin
                bus_drv   = 1'b1;
                state_nxt = IDLE;
            end
            RSETUP: begin
                cnt_nxt   = STROBE_LAST;
                state_nxt = RSTROBE;
            end
            RSTROBE: begin
                ram_re = 1'b1;
                if (cnt == '0) state_nxt = RTURN;
                else           cnt_nxt   = cnt - 1'b1;
            end
            RTURN: begin
                cl.rsp0_valid = (cap_id == 1'b0);
                cl.rsp1_valid = (cap_id == 1'b1);
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: two controllers (STROBE_LEN 1 and 3) each in front of a behavioural RAM.
// Latency: checks accept spacing, read latency and strobe widths against hand-computed values.
// Backpressure: requests held until ready; responses observed as single-cycle pulses.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    ram_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ifa ();
    ram_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ifb ();

    logic        we_a, re_a, we_b, re_b;
    logic [8:0]  addr_a, addr_b;
    wire  [31:0] data_a, data_b;
    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];

    ram_arbiter #(.ADDR_W(9), .DATA_W(32), .STROBE_LEN(1)) u_a (
        .clk(clk), .rst(rst), .cl(ifa),
        .ram_we(we_a), .ram_re(re_a), .ram_addr(addr_a), .ram_data(data_a)
    );

    ram_arbiter #(.ADDR_W(9), .DATA_W(32), .STROBE_LEN(3)) u_b (
        .clk(clk), .rst(rst), .cl(ifb),
        .ram_we(we_b), .ram_re(re_b), .ram_addr(addr_b), .ram_data(data_b)
    );

    // Behavioural RAMs: drive the bus while re is high, capture on we.
    assign data_a = re_a ? mem_a[addr_a] : {32{1'bz}};
    assign data_b = re_b ? mem_b[addr_b] : {32{1'bz}};
    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= data_a;
        if (we_b) mem_b[addr_b] <= data_b;
    end

    // Bus-contention monitor: drive with re high, or drive right after re.
    int   viol = 0;
    logic re_prev_a = 1'b0;
    logic re_prev_b = 1'b0;
    always @(negedge clk) begin
        if ((u_a.bus_drv && (re_a || re_prev_a)) || (u_b.bus_drv && (re_b || re_prev_b)))
            viol <= viol + 1;
        re_prev_a <= re_a;
        re_prev_b <= re_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input int c, input bit v, input bit w,
                         input logic [8:0] a, input logic [31:0] d);
        if (sel == 0) begin
            if (c == 0) begin
                ifa.rq0_valid = v; ifa.rq0_write = w; ifa.rq0_addr = a; ifa.rq0_wdata = d;
            end else begin
                ifa.rq1_valid = v; ifa.rq1_write = w; ifa.rq1_addr = a; ifa.rq1_wdata = d;
            end
        end else begin
            if (c == 0) begin
                ifb.rq0_valid = v; ifb.rq0_write = w; ifb.rq0_addr = a; ifb.rq0_wdata = d;
            end else begin
                ifb.rq1_valid = v; ifb.rq1_write = w; ifb.rq1_addr = a; ifb.rq1_wdata = d;
            end
        end
    endtask

    function automatic logic get_ready(input int sel, input int c);
        if (sel == 0) return (c == 0) ? ifa.rq0_ready : ifa.rq1_ready;
        return (c == 0) ? ifb.rq0_ready : ifb.rq1_ready;
    endfunction

    function automatic logic get_rsp(input int sel, input int c);
        if (sel == 0) return (c == 0) ? ifa.rsp0_valid : ifa.rsp1_valid;
        return (c == 0) ? ifb.rsp0_valid : ifb.rsp1_valid;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel, input int c);
        if (sel == 0) return (c == 0) ? ifa.rsp0_rdata : ifa.rsp1_rdata;
        return (c == 0) ? ifb.rsp0_rdata : ifb.rsp1_rdata;
    endfunction

    // Present one request, wait (bounded) for ready, then withdraw after the accept edge.
    task automatic xact(input int sel, input int c, input bit w, input logic [8:0] a,
                        input logic [31:0] d, output int acc);
        acc = -1;
        drive(sel, c, 1'b1, w, a, d);
        for (int i = 0; i < 50 && acc < 0; i++) begin
            @(negedge clk);
            if (get_ready(sel, c) === 1'b1) acc = cyc;
        end
        @(posedge clk); #1;
        drive(sel, c, 1'b0, 1'b0, 9'd0, 32'd0);
        chk("accepted", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_rsp(input int sel, input int c, output logic [31:0] data, output int rc);
        rc   = -1;
        data = '0;
        for (int i = 0; i < 20 && rc < 0; i++) begin
            @(negedge clk);
            if (get_rsp(sel, c) === 1'b1) begin
                rc   = cyc;
                data = get_rdata(sel, c);
            end
        end
        chk("rsp_seen", 32'(rc >= 0), 32'd1);
    endtask

    task automatic do_reset();
        drive(0, 0, 1'b0, 1'b0, 9'd0, 32'd0);
        drive(0, 1, 1'b0, 1'b0, 9'd0, 32'd0);
        drive(1, 0, 1'b0, 1'b0, 9'd0, 32'd0);
        drive(1, 1, 1'b0, 1'b0, 9'd0, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, 32'(u_a.state), 32'(IDLE));
        chk({tag, "_we"},    32'(we_a), 32'd0);
        chk({tag, "_re"},    32'(re_a), 32'd0);
        chk({tag, "_drv"},   32'(u_a.bus_drv), 32'd0);
        chk({tag, "_addr"},  32'(addr_a), 32'd0);
        chk({tag, "_rsp"},   32'({ifa.rsp1_valid, ifa.rsp0_valid}), 32'd0);
        chk({tag, "_rdy"},   32'({ifa.rq1_ready, ifa.rq0_ready}), 32'd0);
    endtask

    initial begin
        int          acc, acc_prev, rc, n, both, we_cnt, last_re, first_drv, quiet;
        int          g [4];
        logic [31:0] rd, rsp1_dat, rsp0_dat;
        bit          done0, done1, got1, got0;
        logic [31:0] wvals [3];
        wvals[0] = 32'd1; wvals[1] = 32'd2; wvals[2] = 32'd4;

        // Reset state
        do_reset();
        @(negedge clk);
        chk_idle("reset");
        chk("reset_b_we", 32'(we_b), 32'd0);
        chk("reset_b_state", 32'(u_b.state), 32'(IDLE));

        // Client 0 writes 1,2,4 to addresses 0..2, four cycles per write
        acc_prev = -1;
        for (int i = 0; i < 3; i++) begin
            xact(0, 0, 1'b1, 9'(i), wvals[i], acc);
            if (i > 0) chk("write_spacing", 32'(acc - acc_prev), 32'd4);
            acc_prev = acc;
        end
        // Read them back: data and 3-cycle latency
        for (int i = 0; i < 3; i++) begin
            xact(0, 0, 1'b0, 9'(i), 32'd0, acc);
            if (i == 0) chk("write_to_read_spacing", 32'(acc - acc_prev), 32'd4);
            wait_rsp(0, 0, rd, rc);
            chk("read_data", rd, wvals[i]);
            chk("read_latency", 32'(rc - acc), 32'd3);
        end

        // Both clients valid continuously: grants alternate starting with client 0
        do_reset();
        drive(0, 0, 1'b1, 1'b1, 9'd5, 32'h55);
        drive(0, 1, 1'b1, 1'b0, 9'd5, 32'd0);
        n = 0; both = 0; got1 = 1'b0; rsp1_dat = '0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (ifa.rq0_ready && ifa.rq1_ready) both++;
            if (ifa.rq0_ready === 1'b1)      begin g[n] = 0; n++; end
            else if (ifa.rq1_ready === 1'b1) begin g[n] = 1; n++; end
            if (ifa.rsp1_valid === 1'b1 && !got1) begin got1 = 1'b1; rsp1_dat = ifa.rsp1_rdata; end
        end
        @(posedge clk); #1;
        drive(0, 0, 1'b0, 1'b0, 9'd0, 32'd0);
        drive(0, 1, 1'b0, 1'b0, 9'd0, 32'd0);
        chk("rr_grant_count", 32'(n), 32'd4);
        chk("rr_g0", 32'(g[0]), 32'd0);
        chk("rr_g1", 32'(g[1]), 32'd1);
        chk("rr_g2", 32'(g[2]), 32'd0);
        chk("rr_g3", 32'(g[3]), 32'd1);
        chk("rr_single_grant", 32'(both), 32'd0);
        chk("rr_read_data", rsp1_dat, 32'h55);
        repeat (10) @(posedge clk);

        // Read immediately followed by a write: turnaround before the write drives
        do_reset();
        drive(0, 0, 1'b1, 1'b0, 9'd5, 32'd0);
        drive(0, 1, 1'b1, 1'b1, 9'd7, 32'h77);
        done0 = 1'b0; done1 = 1'b0; got0 = 1'b0; rsp0_dat = '0;
        last_re = -1; first_drv = -1;
        for (int i = 0; i < 30 && first_drv < 0; i++) begin
            @(negedge clk);
            if (re_a === 1'b1) last_re = cyc;
            if (u_a.bus_drv === 1'b1 && last_re >= 0) first_drv = cyc;
            if (ifa.rq0_ready === 1'b1) done0 = 1'b1;
            if (ifa.rq1_ready === 1'b1) done1 = 1'b1;
            if (ifa.rsp0_valid === 1'b1) begin got0 = 1'b1; rsp0_dat = ifa.rsp0_rdata; end
            @(posedge clk); #1;
            if (done0) drive(0, 0, 1'b0, 1'b0, 9'd0, 32'd0);
            if (done1) drive(0, 1, 1'b0, 1'b0, 9'd0, 32'd0);
        end
        chk("turn_read_seen", 32'(last_re >= 0), 32'd1);
        chk("turn_gap", 32'(first_drv - last_re >= 2), 32'd1);
        chk("turn_read_data", rsp0_dat, 32'h55);
        repeat (6) @(posedge clk); #1;
        xact(0, 0, 1'b0, 9'd7, 32'd0, acc);
        wait_rsp(0, 0, rd, rc);
        chk("turn_write_landed", rd, 32'h77);

        // Reset during WSTROBE
        xact(0, 0, 1'b1, 9'd10, 32'hAA, acc);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wstrobe_entered", 32'(we_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_wstrobe");
        rst = 1'b0;

        // Reset during RSTROBE: no response may follow
        xact(0, 0, 1'b0, 9'd5, 32'd0, acc);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstrobe_entered", 32'(re_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_rstrobe");
        rst = 1'b0;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.rsp0_valid || ifa.rsp1_valid) quiet++;
        end
        chk("rst_no_rsp", 32'(quiet), 32'd0);

        // STROBE_LEN = 3: write 0xDEADBEEF at 511, read it back
        xact(1, 0, 1'b1, 9'd511, 32'hDEADBEEF, acc);
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (we_b === 1'b1) we_cnt++;
        end
        chk("l3_we_width", 32'(we_cnt), 32'd3);
        xact(1, 0, 1'b0, 9'd511, 32'd0, acc);
        wait_rsp(1, 0, rd, rc);
        chk("l3_read_data", rd, 32'hDEADBEEF);
        chk("l3_read_latency", 32'(rc - acc), 32'd5);

        chk("bus_contention", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin controller for the single-port 512×32 RAM (`we`, `re`, 9-bit `addr`, bidirectional 32-bit `data`). Accepts read and write transactions from two clients over valid/ready handshakes and sequences the RAM strobes. Owns the tri-state `data` bus and guarantees a turnaround cycle, so the bus is never driven by the RAM and the controller at the same time. Sits between the RAM instance and its two clients.

## Interface
- `ADDR_W`, 9: RAM address width.
- `DATA_W`, 32: RAM data width.
- `STROBE_LEN`, 1: cycles `ram_we` / `ram_re` are held high; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rqN_valid`  in  1  request from client N (N = 0, 1); held until accepted.
- `rqN_write`  in  1  1 = write, 0 = read.
- `rqN_addr`  in  ADDR_W  target address.
- `rqN_wdata`  in  DATA_W  write data; ignored for reads.
- `rqN_ready`  out  1  request accepted at this edge when `rqN_valid` is also high.
- `rspN_valid`  out  1  one-cycle pulse carrying read data; no backpressure.
- `rspN_rdata`  out  DATA_W  read data; valid only while `rspN_valid` is high.
- `ram_we`  out  1  RAM write enable.
- `ram_re`  out  1  RAM output enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_data`  inout  DATA_W  driven with write data only during write states; `'z` otherwise.

## Operation
- States: IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RSTROBE, RTURN.
- IDLE: the arbiter picks a grant from the valid requests. Only the granted client sees `rqN_ready` = 1, combinationally from IDLE, the valid inputs and the priority pointer. On handshake, `addr`, `wdata`, `write` and the client id are registered, and the FSM moves to WSETUP or RSETUP.
- Round-robin: the priority pointer flips to the other client after every accepted transaction. A lone requester is granted every time.
- Write path: WSETUP (1 cycle) drives `ram_addr` and the bus with `ram_we` = 0. WSTROBE holds `ram_we` = 1 for STROBE_LEN cycles, tracked by a down-counter. WHOLD (1 cycle) keeps the bus and address driven with `ram_we` = 0. The FSM then returns to IDLE.
- Read path: RSETUP (1 cycle) drives `ram_addr` with the bus released. RSTROBE holds `ram_re` = 1 for STROBE_LEN cycles. `ram_data` is sampled at the edge ending the last RSTROBE cycle. RTURN (1 cycle) has `ram_re` = 0 and raises `rspN_valid` for the owning client with the sampled data. The FSM then returns to IDLE.
- Invariants:
  - Bus-drive enable and `ram_re` are never high together.
  - At least one cycle with both low separates `ram_re` falling from the next bus drive.
  - `ram_addr` is stable from SETUP through HOLD/RTURN.
- Reset, including mid-transaction:
  - State returns to IDLE.
  - `ram_we`, `ram_re`, `rqN_ready` (as seen after reset) and `rspN_valid` are 0.
  - `ram_addr` is 0 and the bus is `'z`.
  - The pointer favours client 0 and the strobe counter is 0.
  - An interrupted write may or may not have landed in the RAM. An interrupted read produces no response.

## Timing
- Write occupancy: 2 + STROBE_LEN cycles after the accept edge, plus 1 IDLE cycle before the next accept. That is 4 cycles per write at STROBE_LEN = 1.
- Read latency: `rspN_valid` is high 2 + STROBE_LEN cycles after the accept edge. That is 3 cycles at STROBE_LEN = 1. A new accept is possible in the IDLE cycle that follows.
- Simultaneous valids in IDLE: only the pointer-favoured client is granted. The other keeps `valid` high and is granted in the next IDLE.
- `rqN_valid` dropped before ready: no transaction occurs; legal.
- Address wrap: 511 is the last address. No incrementing is done internally.

## Structure
- Package `ram_arbiter_pkg`: state enum, ADDR_W/DATA_W defaults, client-id type.
- Sub-module `rr_arbiter2`: two-request round-robin grant with pointer update on an `accept` strobe.
- The FSM, strobe counter, capture registers and tri-state driver live in `ram_arbiter`.

## Test plan
- Client 0 writes 1, 2, 4 to addresses 0, 1, 2, then reads them back. Required: reads return 1, 2, 4 with `rsp0_valid` exactly 3 cycles after each accept.
- Both clients hold valid continuously, client 0 writing and client 1 reading address 5. Required: grants alternate 0,1,0,1, starting with client 0 after reset.
- Write 0xDEADBEEF to address 511, then read address 511 with STROBE_LEN = 3. Required: `ram_we` high for exactly 3 cycles, and the read returns 0xDEADBEEF 5 cycles after its accept.
- Read immediately followed by a write. Required: a checker confirms no cycle has both bus drive and `ram_re` high, and at least one idle-bus cycle precedes the write's WSETUP.
- Assert `rst` during WSTROBE, and separately during RSTROBE. Required: next cycle shows IDLE, `ram_we` = `ram_re` = 0, bus `'z`, and no `rspN_valid` pulse.
